zjh_cc_tf_serial: RTL
=====================

# zjh_cc_tf_serial

Sequential two's-complement ("complement code") to sign-magnitude ("true form") converter. It is the inverse of the combinational true-form-to-complement converter already in the design. It accepts one W-bit two's-complement word through a valid/ready handshake and negates the magnitude bit-serially, LSB first: bits are copied up to and including the first 1, then inverted. It returns the sign-magnitude result through a second valid/ready handshake, and flags the one input that has no sign-magnitude encoding.

## Interface
- W, default 4: data width including the sign bit; W >= 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  cc_in holds a word to convert.
- in_ready  out  1  block can accept a word; high only in IDLE.
- cc_in  in  W  two's-complement input; cc_in[W-1] is the sign.
- out_valid  out  1  tf_out/ovf hold a result; high only in DONE.
- out_ready  in  1  consumer takes the result.
- tf_out  out  W  sign-magnitude result; tf_out[W-1] is the sign.
- ovf  out  1  input was the most negative value (1 followed by W-1 zeros), so it has no W-bit sign-magnitude form.

## Operation
- State machine: IDLE, SHIFT, DONE.
- IDLE
  - in_ready=1.
  - On in_valid=1: latch sign = cc_in[W-1] and work = cc_in[W-2:0].
  - Clear seen_one and cnt.
  - Go to SHIFT.
- SHIFT
  - Each cycle processes one magnitude bit b = work[0]. Shift work right by 1 and insert the result bit at work[W-2].
  - If sign=0: result bit = b.
  - If sign=1: result bit = b XOR seen_one. Then seen_one |= b.
  - cnt increments from 0 to W-2. After the edge that processes cnt=W-2, go to DONE.
- DONE entry, same edge as the last SHIFT bit:
  - tf_out = {sign, final magnitude}.
  - ovf = sign AND (original magnitude bits all zero), i.e. seen_one still 0 with sign=1.
  - On overflow, tf_out = {1, zeros}.
  - A positive zero gives tf_out = 0, ovf = 0.
- DONE
  - out_valid=1. tf_out and ovf are held stable.
  - On out_ready=1, return to IDLE.
  - tf_out and ovf keep their values in IDLE and SHIFT. They change only on DONE entry or reset.
- Magnitude arithmetic: for sign=1 and m = cc_in[W-2:0] != 0, magnitude = 2^(W-1) - m. This is exact in W-1 bits. No other input overflows.
- in_valid while not in IDLE: ignored; the word is not consumed.
- cc_in is sampled only at the accept edge. Later changes have no effect.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, tf_out=0, ovf=0, internal registers 0.
- Reset takes effect immediately, in any state. An in-flight word is discarded with no output.
- Handshakes:
  - Input transfer happens on a rising edge with in_valid=1 and in_ready=1 (edge T).
  - SHIFT occupies edges T+1 to T+W-1.
  - out_valid rises after edge T+W-1: W-1 cycles of latency, 3 for W=4.
  - Output transfer happens on an edge with out_valid=1 and out_ready=1. out_valid falls after it and in_ready rises after it.
- No input is accepted in the same cycle as the output transfer. Peak throughput is one word per W+1 cycles.
- out_ready asserted early (in IDLE or SHIFT) has no effect. If out_ready is held at 1, DONE lasts exactly one cycle.
- All outputs are registered or decoded from state only. There are no combinational in-to-out paths.

## Test plan
- W=4, cc_in=0101 (+5), out_ready=1 -> tf_out=0101, ovf=0; out_valid high exactly 3 cycles after the accept edge, for one cycle.
- cc_in=1011 (-5) -> 1101; cc_in=1111 (-1) -> 1001; cc_in=1110 (-2) -> 1010; all with ovf=0.
- cc_in=1000 (-8) -> tf_out=1000, ovf=1. Then cc_in=0000 -> tf_out=0000, ovf=0 (ovf clears).
- Backpressure: convert 0001 with out_ready=0 for 5 cycles, and in_valid=1 with cc_in=1010 meanwhile.
  - Required: in_ready=0 throughout; tf_out=0001 stable.
  - Then out_ready=1 -> return to IDLE, accept 1010 on the next edge -> tf_out=1110.
- Reset mid-SHIFT: accept 0110, pulse rst on the second SHIFT cycle.
  - Required: out_valid=0, tf_out=0000, in_ready=1 immediately.
  - After release, 1110 -> 1010 with normal latency.
- Exhaustive: all 16 inputs back to back, scoreboard against the sign-magnitude formula; ovf=1 only for 1000.

Source files
------------

// File: rtl/zjh_cc_tf_serial.sv
// Bit-serial two's-complement to sign-magnitude converter.
// One word per handshake; magnitude is negated LSB first.
module zjh_cc_tf_serial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] cc_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] tf_out,
  output logic         ovf
);

  localparam int CW = (W > 2) ? $clog2(W - 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          sign;
  logic [W-2:0]  work;
  logic          seen_one;
  logic [CW-1:0] cnt;

  logic          b;
  logic          rbit;
  logic          seen_nxt;
  logic [W-1:0]  cat;
  logic [W-2:0]  work_nxt;
  logic          last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Copy bits through the first 1, invert the rest (only when negative).
  assign b        = work[0];
  assign rbit     = sign ? (b ^ seen_one) : b;
  assign seen_nxt = seen_one | b;
  assign cat      = {rbit, work} >> 1;
  assign work_nxt = cat[W-2:0];
  assign last     = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign     <= 1'b0;
      work     <= '0;
      seen_one <= 1'b0;
      cnt      <= '0;
      tf_out   <= '0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign     <= cc_in[W-1];
            work     <= cc_in[W-2:0];
            seen_one <= 1'b0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          work     <= work_nxt;
          seen_one <= seen_nxt;
          cnt      <= cnt + 1'b1;
          if (last) begin
            // A negative zero magnitude is the unrepresentable minimum.
            tf_out <= {sign, work_nxt};
            ovf    <= sign & ~seen_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
